// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, drives the ROM, and registers the fetched word into IF/ID.
// Optional misaligned-fetch flagging is enabled by defining IF_ADDR_ERR_EN.
module inst_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst,
  output logic              if_valid,
  output logic              if_addr_err
);

  typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic              pend_vld_q;
  logic [ADDR_W-1:0] pend_pc_q;
  logic              rom_ce_q;
  logic [ADDR_W-1:0] if_pc_q;
  logic [INST_W-1:0] if_inst_q;
  logic              if_valid_q;
  logic              if_err_q;
  logic              misaligned;

`ifdef IF_ADDR_ERR_EN
  assign misaligned = |pc_q[1:0];
`else
  assign misaligned = 1'b0;
`endif

  // Next fetch address when running: a fresh branch beats a pending one, which beats pc+4.
  always_comb begin
    pc_d = pc_q + ADDR_W'(4);
    if (branch_flag_i)   pc_d = branch_target_i;
    else if (pend_vld_q) pc_d = pend_pc_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      pend_vld_q <= 1'b0;
      rom_ce_q   <= 1'b0;
      if_pc_q    <= '0;
      if_inst_q  <= '0;
      if_valid_q <= 1'b0;
      if_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q  <= RUN;
          rom_ce_q <= 1'b1;
        end
        default: begin
          if (flush) begin
            state_q    <= RUN;
            pc_q       <= new_pc;
            pend_vld_q <= 1'b0;
            if_pc_q    <= '0;
            if_inst_q  <= '0;
            if_valid_q <= 1'b0;
            if_err_q   <= 1'b0;
          end else if (stall) begin
            state_q <= STALL;
            if (branch_flag_i) pend_vld_q <= 1'b1;
          end else begin
            state_q    <= RUN;
            pc_q       <= pc_d;
            pend_vld_q <= 1'b0;
            if_pc_q    <= pc_q;
            if_inst_q  <= misaligned ? '0 : rom_inst;
            if_valid_q <= 1'b1;
            if_err_q   <= misaligned;
          end
        end
      endcase
    end
  end

  // Pending target is plain data; its validity lives in pend_vld_q.
  always_ff @(posedge clk) begin
    if (state_q != IDLE && !flush && stall && branch_flag_i)
      pend_pc_q <= branch_target_i;
  end

  assign rom_ce      = rom_ce_q;
  assign rom_addr    = pc_q;
  assign if_pc       = if_pc_q;
  assign if_inst     = if_inst_q;
  assign if_valid    = if_valid_q;
  assign if_addr_err = if_err_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: directed per-cycle vectors against a combinational ROM model.
module tb_inst_fetch;

`ifdef IF_ADDR_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] new_pc = '0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        if_addr_err;

  int npass = 0;
  int ntot  = 0;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
    logic [31:0] addr;
  } exp_t;
  exp_t q[$];

  inst_fetch #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid), .if_addr_err(if_addr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_f(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
  endfunction

  assign rom_inst = rom_f(rom_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    ntot++;
    if (act === req) npass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // One clock: apply inputs, queue the IF/ID and fetch-address state expected after the edge.
  task automatic step(input bit st, input bit fl, input logic [31:0] np,
                      input bit br, input logic [31:0] tg,
                      input bit ev, input logic [31:0] epc, input logic [31:0] eaddr);
    exp_t e;
    @(negedge clk);
    stall = st; flush = fl; new_pc = np; branch_flag_i = br; branch_target_i = tg;
    e.v    = ev;
    e.pc   = epc;
    e.err  = ERR_EN && ev && (epc[1:0] != 2'b00);
    e.inst = (!ev || e.err) ? 32'h0 : rom_f(epc);
    e.addr = eaddr;
    q.push_back(e);
    @(posedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("valid_pc", {31'b0, if_valid, if_pc}, {31'b0, e.v, e.pc});
      check("inst_err", {31'b0, if_addr_err, if_inst}, {31'b0, e.err, e.inst});
      check("ce_addr", {31'b0, rom_ce, rom_addr}, {31'b0, 1'b1, e.addr});
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_ce", {63'b0, rom_ce}, 64'd0);
    check("reset_if", {31'b0, if_valid, if_pc}, 64'd0);
    check("reset_addr", {32'b0, rom_addr}, 64'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;
    check("idle_exit", {31'b0, rom_ce, if_valid, if_pc}, {31'b0, 1'b1, 1'b0, 32'h0});

    // sequential fetch
    step(0,0,0,0,0, 1,32'h00,32'h04);
    step(0,0,0,0,0, 1,32'h04,32'h08);
    step(0,0,0,0,0, 1,32'h08,32'h0C);
    step(0,0,0,0,0, 1,32'h0C,32'h10);
    // stall three cycles at pc 0x10
    step(1,0,0,0,0, 1,32'h0C,32'h10);
    step(1,0,0,0,0, 1,32'h0C,32'h10);
    step(1,0,0,0,0, 1,32'h0C,32'h10);
    step(0,0,0,0,0, 1,32'h10,32'h14);
    step(0,0,0,0,0, 1,32'h14,32'h18);
    step(0,0,0,0,0, 1,32'h18,32'h1C);
    step(0,0,0,0,0, 1,32'h1C,32'h20);
    // branch at pc 0x20 to 0x100 (delay slot captured)
    step(0,0,0,1,32'h100, 1,32'h20,32'h100);
    step(0,0,0,0,0,       1,32'h100,32'h104);
    step(0,0,0,0,0,       1,32'h104,32'h108);
    // branch arrives during stall, taken when stall drops
    step(1,0,0,1,32'h200, 1,32'h104,32'h108);
    step(1,0,0,0,0,       1,32'h104,32'h108);
    step(1,0,0,0,0,       1,32'h104,32'h108);
    step(0,0,0,0,0,       1,32'h108,32'h200);
    step(0,0,0,0,0,       1,32'h200,32'h204);
    // later pending branch overwrites earlier
    step(1,0,0,1,32'h300, 1,32'h200,32'h204);
    step(1,0,0,1,32'h340, 1,32'h200,32'h204);
    step(0,0,0,0,0,       1,32'h204,32'h340);
    step(0,0,0,0,0,       1,32'h340,32'h344);
    // live branch beats pending one and clears it
    step(1,0,0,1,32'h400, 1,32'h340,32'h344);
    step(0,0,0,1,32'h500, 1,32'h344,32'h500);
    step(0,0,0,0,0,       1,32'h500,32'h504);
    // flush together with stall
    step(1,1,32'h180,0,0, 0,32'h0,32'h180);
    step(0,0,0,0,0,       1,32'h180,32'h184);
    // flush discards a pending branch
    step(1,0,0,1,32'h600, 1,32'h180,32'h184);
    step(0,1,32'h700,0,0, 0,32'h0,32'h700);
    step(0,0,0,0,0,       1,32'h700,32'h704);
    // PC wrap at top of address space
    step(0,0,0,1,32'hFFFF_FFF8, 1,32'h704,32'hFFFF_FFF8);
    step(0,0,0,0,0,             1,32'hFFFF_FFF8,32'hFFFF_FFFC);
    step(0,0,0,0,0,             1,32'hFFFF_FFFC,32'h0);
    // misaligned branch target
    step(0,0,0,1,32'h102, 1,32'h0,32'h102);
    step(0,0,0,0,0,       1,32'h102,32'h106);
    step(0,0,0,1,32'h40,  1,32'h106,32'h40);
    step(0,0,0,0,0,       1,32'h40,32'h44);
    // pending branch, then reset mid-operation
    step(1,0,0,1,32'h800, 1,32'h40,32'h44);
    #3 rst = 1'b0;
    #1;
    check("midrst_ce", {63'b0, rom_ce}, 64'd0);
    check("midrst_if", {31'b0, if_valid, if_pc}, 64'd0);
    check("midrst_addr", {32'b0, rom_addr}, 64'd0);
    @(negedge clk) begin rst = 1'b1; stall = 1'b0; branch_flag_i = 1'b0; end
    @(posedge clk) #1;
    check("midrst_idle_exit", {31'b0, rom_ce, if_valid, if_pc}, {31'b0, 1'b1, 1'b0, 32'h0});
    step(0,0,0,0,0, 1,32'h0,32'h4);
    step(0,0,0,0,0, 1,32'h4,32'h8);

    @(posedge clk) #2;
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
